// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Every output comes from a register. Flush or an empty state presents a NOP bubble to decode.
module if_id_skid_reg #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter logic [ADDR_W-1:0]  RESET_NPC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  npc_if,
    input  logic [INSTR_W-1:0] instr_if,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  npc_id,
    output logic [INSTR_W-1:0] instr_id,
    output logic [1:0]         count
);

    // Each encoding equals the number of entries held, so count is the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  main_npc_q, main_npc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [ADDR_W-1:0]  skid_npc_q, skid_npc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               push, pop;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign count     = 2'(state_q);
    assign npc_id    = main_npc_q;
    assign instr_id  = main_instr_q;

    always_comb begin
        push         = in_valid && (state_q != ST_FULL);
        pop          = out_ready && (state_q != ST_EMPTY);
        state_d      = state_q;
        main_npc_d   = main_npc_q;
        main_instr_d = main_instr_q;
        skid_npc_d   = skid_npc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            main_npc_d   = RESET_NPC;
            main_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d      = ST_ONE;
                        main_npc_d   = npc_if;
                        main_instr_d = instr_if;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_npc_d   = npc_if;
                        main_instr_d = instr_if;
                    end else if (push) begin
                        // Decode stalled: the younger entry parks in the skid register.
                        state_d      = ST_FULL;
                        skid_npc_d   = npc_if;
                        skid_instr_d = instr_if;
                    end else if (pop) begin
                        state_d      = ST_EMPTY;
                        main_npc_d   = RESET_NPC;
                        main_instr_d = NOP_INSTR;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d      = ST_ONE;
                        main_npc_d   = skid_npc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_npc_d   = RESET_NPC;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_npc_q   <= RESET_NPC;
            main_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            main_npc_q   <= main_npc_d;
            main_instr_q <= main_instr_d;
        end
    end

    // The skid register is only ever observed through main, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_npc_q   <= skid_npc_d;
        skid_instr_q <= skid_instr_d;
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: a queue model of in-order entries, checked every cycle,
// plus hand-computed directed checks. The bench drives a default instance and a narrow instance.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] npc_if = '0;
    logic [31:0] instr_if = '0;

    logic        in_ready1, out_valid1;
    logic [31:0] npc_id1, instr_id1;
    logic [1:0]  count1;

    logic        in_ready2, out_valid2;
    logic [15:0] npc_id2;
    logic [23:0] instr_id2;
    logic [1:0]  count2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          check_en = 1'b0;

    always #5 clk = ~clk;

    if_id_skid_reg u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .npc_if(npc_if), .instr_if(instr_if),
        .out_valid(out_valid1), .out_ready(out_ready),
        .npc_id(npc_id1), .instr_id(instr_id1), .count(count1)
    );

    if_id_skid_reg #(
        .ADDR_W(16), .INSTR_W(24),
        .NOP_INSTR(24'hABCDEF), .RESET_NPC(16'h0100)
    ) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .npc_if(npc_if[15:0]), .instr_if(instr_if[23:0]),
        .out_valid(out_valid2), .out_ready(out_ready),
        .npc_id(npc_id2), .instr_id(instr_id2), .count(count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the in-flight instructions in program order; the oldest is what decode sees.
    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
    } ent_t;
    ent_t mq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            automatic bit   m_push = in_valid && (mq.size() < 2);
            automatic bit   m_pop  = out_ready && (mq.size() > 0);
            automatic ent_t e;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    e.npc   = npc_if;
                    e.instr = instr_if;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            automatic logic [31:0] e_npc   = 32'h0;
            automatic logic [31:0] e_instr = 32'h0;
            automatic logic [15:0] e_npc2  = 16'h0100;
            automatic logic [23:0] e_ins2  = 24'hABCDEF;
            if (mq.size() > 0) begin
                e_npc   = mq[0].npc;
                e_instr = mq[0].instr;
                e_npc2  = e_npc[15:0];
                e_ins2  = e_instr[23:0];
            end
            chk("m1_out_valid", 64'(out_valid1), 64'(mq.size() > 0));
            chk("m1_in_ready",  64'(in_ready1),  64'(mq.size() < 2));
            chk("m1_count",     64'(count1),     64'(mq.size()));
            chk("m1_npc_id",    64'(npc_id1),    64'(e_npc));
            chk("m1_instr_id",  64'(instr_id1),  64'(e_instr));
            chk("m2_out_valid", 64'(out_valid2), 64'(mq.size() > 0));
            chk("m2_in_ready",  64'(in_ready2),  64'(mq.size() < 2));
            chk("m2_count",     64'(count2),     64'(mq.size()));
            chk("m2_npc_id",    64'(npc_id2),    64'(e_npc2));
            chk("m2_instr_id",  64'(instr_id2),  64'(e_ins2));
        end
    end

    // Apply one cycle of inputs and return 1 time unit after the rising edge.
    task automatic step(input bit v, input logic [31:0] npc, input logic [31:0] ins,
                        input bit ordy, input bit fl);
        in_valid  = v;
        npc_if    = npc;
        instr_if  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input bit v, input bit rdy, input logic [1:0] cnt,
                        input logic [31:0] npc, input logic [31:0] ins);
        chk({name, "_valid"}, 64'(out_valid1), 64'(v));
        chk({name, "_ready"}, 64'(in_ready1),  64'(rdy));
        chk({name, "_count"}, 64'(count1),     64'(cnt));
        chk({name, "_npc"},   64'(npc_id1),    64'(npc));
        chk({name, "_instr"}, 64'(instr_id1),  64'(ins));
    endtask

    localparam logic [31:0] IA = 32'h1111_A013;
    localparam logic [31:0] IB = 32'h2222_B013;
    localparam logic [31:0] IC = 32'h3333_C013;
    localparam logic [31:0] ID = 32'h4444_D013;
    localparam logic [31:0] IE = 32'h5555_E013;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk1("reset", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
        chk("reset_n2_instr", 64'(instr_id2), 64'(24'hABCDEF));
        chk("reset_n2_npc",   64'(npc_id2),   64'(16'h0100));
        rst      = 1'b0;
        check_en = 1'b1;

        // Streaming: one per cycle, outputs one cycle behind, count stays 1.
        step(1'b1, 32'd4,  IA, 1'b1, 1'b0);
        chk1("str_a", 1'b1, 1'b1, 2'd1, 32'd4, IA);
        chk("str_a_n2", 64'(instr_id2), 64'(24'h11A013));
        step(1'b1, 32'd8,  IB, 1'b1, 1'b0);
        chk1("str_b", 1'b1, 1'b1, 2'd1, 32'd8, IB);
        step(1'b1, 32'd12, IC, 1'b1, 1'b0);
        chk1("str_c", 1'b1, 1'b1, 2'd1, 32'd12, IC);
        chk("str_c_n2", 64'(instr_id2), 64'(24'h33C013));
        step(1'b0, 32'd0,  32'h0, 1'b1, 1'b0);
        chk1("bubble", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
        chk("bubble_n2", 64'(instr_id2), 64'(24'hABCDEF));

        // Stall: decode stops as A appears; B goes to skid; C held off until release.
        step(1'b1, 32'd4,  IA, 1'b0, 1'b0);
        chk1("stl_a", 1'b1, 1'b1, 2'd1, 32'd4, IA);
        step(1'b1, 32'd8,  IB, 1'b0, 1'b0);
        chk1("stl_full", 1'b1, 1'b0, 2'd2, 32'd4, IA);
        step(1'b1, 32'd12, IC, 1'b0, 1'b0);
        chk1("stl_hold", 1'b1, 1'b0, 2'd2, 32'd4, IA);
        step(1'b1, 32'd12, IC, 1'b1, 1'b0);
        chk1("stl_rel_b", 1'b1, 1'b1, 2'd1, 32'd8, IB);
        step(1'b1, 32'd12, IC, 1'b1, 1'b0);
        chk1("stl_c", 1'b1, 1'b1, 2'd1, 32'd12, IC);
        step(1'b0, 32'd0,  32'h0, 1'b1, 1'b0);
        chk1("stl_empty", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);

        // Flush while FULL drops both held entries and the offered D.
        step(1'b1, 32'd4,  IA, 1'b0, 1'b0);
        step(1'b1, 32'd8,  IB, 1'b0, 1'b0);
        chk1("fl_full", 1'b1, 1'b0, 2'd2, 32'd4, IA);
        step(1'b1, 32'd16, ID, 1'b1, 1'b1);
        chk1("fl_bubble", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
        step(1'b0, 32'd0,  32'h0, 1'b1, 1'b0);
        chk1("fl_no_d", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
        step(1'b1, 32'd20, IE, 1'b0, 1'b0);
        chk1("fl_e", 1'b1, 1'b1, 2'd1, 32'd20, IE);

        // Asynchronous reset mid-cycle while FULL.
        step(1'b1, 32'd24, IA, 1'b0, 1'b0);
        chk1("rs_full", 1'b1, 1'b0, 2'd2, 32'd20, IE);
        rst = 1'b1;
        #1;
        chk1("rs_async", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
        chk("rs_async_n2", 64'(instr_id2), 64'(24'hABCDEF));
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 32'd28, IB, 1'b1, 1'b0);
        chk1("rs_first", 1'b1, 1'b1, 2'd1, 32'd28, IB);

        // Mixed traffic, checked against the model every cycle.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
        end
        step(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);
        chk1("drain", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);

        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
